stepmotor_phase_decoder: RTL and testbench
==========================================

Name: stepmotor_phase_decoder

Overview:
Monitors a 4-bit two-phase stepper drive bus (D,C,B,A = phase_in[3:0]) and recovers step events, rotation direction and a signed position count. It is the receiving end of the two-phase-on stepper driver. It validates the phase sequence and flags illegal patterns and skipped steps. Typical uses are closed-loop checking of the stepper driver outputs on the board and reading the decoded position out on LEDs or a display.

Parameters:
CNT_WIDTH, 16, width of the signed position counter
STABLE_CYCLES, 4, consecutive identical synchronized samples needed to accept a pattern (legal range 1..255)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
phase_in  input  4  phase lines {D,C,B,A}, asynchronous to clk
clr_pos  input  1  synchronous; zeroes pos
clr_err  input  1  synchronous; clears error flags, exits FAULT
step_pulse  output  1  one-cycle pulse per accepted legal step
dir  output  1  direction of last step: 1 forward, 0 reverse
pos  output  CNT_WIDTH  signed position, two's complement
valid  output  1  high while in TRACK
err_illegal  output  1  sticky: illegal pattern accepted
err_skip  output  1  sticky: two-position jump accepted

Behaviour:
- Reset (rst=0, async): sync and filter registers = 4'b0000, filter counter = 0, state = IDLE, step_pulse=0, dir=1, pos=0, valid=0, err_illegal=0, err_skip=0.
- Phase codes and indices:
  - 4'b0101 (AC) = 0
  - 4'b1001 (DA) = 1
  - 4'b1010 (BD) = 2
  - 4'b0110 (CB) = 3
  - 4'b0000 = OFF (de-energised)
  - All other codes are illegal.
- Synchronizer: 2 flops on phase_in.
- Filter:
  - If the synchronized value differs from the candidate, load candidate and set the counter to 1.
  - Otherwise the counter increments, saturating at STABLE_CYCLES.
  - When the counter reaches STABLE_CYCLES and candidate differs from the accepted pattern, update the accepted pattern and raise an internal one-cycle "new" strobe.
- Latency: a new phase_in value first sampled at edge E0 produces step_pulse high for exactly the cycle following edge E0+STABLE_CYCLES+2 (E0+6 at default). Glitches shorter than STABLE_CYCLES cycles are never accepted.
- Direction delta: delta = (new_idx - last_idx) mod 4.
- FSM, evaluated on the "new" strobe:
  - IDLE:
    - Legal code: last_idx <= idx; go to TRACK. No step, pos unchanged.
    - OFF: stay in IDLE.
    - Illegal: err_illegal <= 1; go to FAULT.
  - TRACK:
    - delta=1: step_pulse, dir <= 1, pos+1.
    - delta=3: step_pulse, dir <= 0, pos-1.
    - delta=2: err_skip <= 1; go to FAULT. pos unchanged.
    - delta=0: cannot occur, because the strobe fires only on change.
    - On any accepted legal code, last_idx <= idx.
    - OFF: go to IDLE with no error; pos and dir hold.
    - Illegal: err_illegal <= 1; go to FAULT.
  - FAULT:
    - Ignore strobes; pos holds; valid=0.
    - clr_err: clear both flags; go to IDLE; resync on the next accepted legal code.
- clr_err outside FAULT clears the flags only.
- pos arithmetic: wraps modulo 2^CNT_WIDTH (0x7FFF + 1 = 0x8000; 0 - 1 = 0xFFFF).
- clr_pos together with a step: pos <= 0, while step_pulse and dir still update. clr_pos is honoured in every state.
- clr_err in the same cycle as a fault-causing strobe: the fault wins; the flag sets and the state becomes FAULT.
- Reset mid-step: all state is discarded immediately. After release, the first accepted legal code only resyncs; no step is counted.

Decomposition:
- Shared include file (stepmotor_defs.vh): the four phase-code localparams (PH_AC, PH_DA, PH_BD, PH_CB), PH_OFF, and FSM state encodings IDLE, TRACK, FAULT. The existing driver should also use these codes.
- One sub-module, step_phase_filter: 2-flop synchronizer plus stability filter. Ports: clk, rst, din[3:0], dout[3:0], new_strobe. Parameter: STABLE_CYCLES.
- Top level: decode, FSM, position counter.

Test Plan:
1. Reset, then drive 0101, 1001, 1010, 0110, 0101, each held 20 cycles. Expect the first code to resync only, then 4 step_pulses, dir=1, pos=4, valid=1, no errors.
2. From pos=4 drive 0101, 0110, 1010. Expect 2 pulses, dir=0, pos=2. Each pulse lands exactly STABLE_CYCLES+2 edges after the change is sampled.
3. While in TRACK on 0101, apply 1001 for 3 cycles, then return to 0101. Expect no step_pulse and pos unchanged. Repeat holding 1001 for 4 cycles: expect exactly 1 step.
4. From 0101, drive 1010. Expect err_skip=1, FAULT, valid=0, and further legal steps ignored. Pulse clr_err: flags clear, the next code resyncs, and the following step counts.
5. Drive 1111. Expect err_illegal=1. Separately, drive 0000 in TRACK: expect IDLE with no error and pos held.
6. With CNT_WIDTH=16 preset to 0x7FFF, take a forward step: expect pos=0x8000. Assert clr_pos coincident with a step: expect pos=0 and step_pulse=1.

Source files
------------

// File: rtl/stepmotor_phase_decoder_pkg.sv
// Shared phase codes, FSM states and phase decode helper
// for the two-phase stepper driver and its decoder.
package stepmotor_phase_decoder_pkg;

   // Drive codes on {D,C,B,A}, in forward sequence order
   localparam logic [3:0] PH_AC  = 4'b0101;
   localparam logic [3:0] PH_DA  = 4'b1001;
   localparam logic [3:0] PH_BD  = 4'b1010;
   localparam logic [3:0] PH_CB  = 4'b0110;
   localparam logic [3:0] PH_OFF = 4'b0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_t;

   typedef struct packed {
      logic       legal;
      logic       off;
      logic [1:0] idx;
   } phase_dec_t;

   function automatic phase_dec_t phase_decode(
      input logic [3:0] code
   );
      phase_dec_t d;
      d = '0;
      case (code)
         PH_AC:  begin d.legal = 1'b1; d.idx = 2'd0; end
         PH_DA:  begin d.legal = 1'b1; d.idx = 2'd1; end
         PH_BD:  begin d.legal = 1'b1; d.idx = 2'd2; end
         PH_CB:  begin d.legal = 1'b1; d.idx = 2'd3; end
         PH_OFF: d.off = 1'b1;
         default: d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/stepmotor_phase_decoder_filter.sv
// Two-flop synchronizer plus stability filter for phase lines.
// Ports: clk, rst (async low), din, dout (accepted), new_strobe.
module step_phase_filter #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] din,
   output logic [3:0] dout,
   output logic       new_strobe
);

   localparam logic [7:0] SC = 8'(STABLE_CYCLES);

   logic [3:0] sync1;
   logic [3:0] sync2;
   logic [3:0] cand;
   logic [3:0] cand_n;
   logic [7:0] cnt;
   logic [7:0] cnt_n;
   logic       accept;

   always_comb begin
      cand_n = cand;
      cnt_n  = cnt;
      if (sync2 != cand) begin
         cand_n = sync2;
         cnt_n  = 8'd1;
      end else if (cnt < SC) begin
         cnt_n = cnt + 8'd1;
      end
   end

   // Strobe is registered from the next-state view so the
   // decoder sees it the same edge the counter saturates.
   assign accept = (cnt_n == SC) && (cand_n != dout);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1      <= 4'b0000;
         sync2      <= 4'b0000;
         cand       <= 4'b0000;
         cnt        <= 8'd0;
         dout       <= 4'b0000;
         new_strobe <= 1'b0;
      end else begin
         sync1      <= din;
         sync2      <= sync1;
         cand       <= cand_n;
         cnt        <= cnt_n;
         new_strobe <= accept;
         if (accept)
            dout <= cand_n;
      end
   end

endmodule

// File: rtl/stepmotor_phase_decoder.sv
// Recovers steps, direction and signed position from a stepper bus.
// Ports: clk, rst, phase_in, clr_pos, clr_err -> step_pulse, dir,
//        pos, valid, err_illegal, err_skip.
module stepmotor_phase_decoder
   import stepmotor_phase_decoder_pkg::*;
#(
   parameter int CNT_WIDTH     = 16,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [3:0]                  phase_in,
   input  logic                        clr_pos,
   input  logic                        clr_err,
   output logic                        step_pulse,
   output logic                        dir,
   output logic signed [CNT_WIDTH-1:0] pos,
   output logic                        valid,
   output logic                        err_illegal,
   output logic                        err_skip
);

   localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

   logic [3:0]           code;
   logic                 strobe;
   phase_dec_t           dec;
   logic [1:0]           delta;

   state_t               state;
   state_t               state_n;
   logic [1:0]           last_idx;
   logic [1:0]           last_n;
   logic                 pulse_n;
   logic                 dir_n;
   logic [CNT_WIDTH-1:0] pos_n;
   logic                 ill_n;
   logic                 skip_n;

   step_phase_filter #(
      .STABLE_CYCLES(STABLE_CYCLES)
   ) u_filt (
      .clk       (clk),
      .rst       (rst),
      .din       (phase_in),
      .dout      (code),
      .new_strobe(strobe)
   );

   assign dec   = phase_decode(code);
   assign delta = dec.idx - last_idx;
   assign valid = (state == TRACK);

   always_comb begin
      state_n = state;
      last_n  = last_idx;
      pulse_n = 1'b0;
      dir_n   = dir;
      pos_n   = pos;
      ill_n   = err_illegal;
      skip_n  = err_skip;

      if (clr_err) begin
         ill_n  = 1'b0;
         skip_n = 1'b0;
         if (state == FAULT)
            state_n = IDLE;
      end

      // Fault detection runs after the clear so it wins.
      if (strobe && state != FAULT) begin
         unique case (1'b1)
            dec.off: state_n = IDLE;
            dec.legal: begin
               last_n = dec.idx;
               if (state == IDLE) begin
                  state_n = TRACK;
               end else begin
                  unique case (delta)
                     2'd1: begin
                        pulse_n = 1'b1;
                        dir_n   = 1'b1;
                        pos_n   = pos + ONE;
                     end
                     2'd3: begin
                        pulse_n = 1'b1;
                        dir_n   = 1'b0;
                        pos_n   = pos - ONE;
                     end
                     2'd2: begin
                        skip_n  = 1'b1;
                        state_n = FAULT;
                     end
                     default: ;
                  endcase
               end
            end
            default: begin
               ill_n   = 1'b1;
               state_n = FAULT;
            end
         endcase
      end

      if (clr_pos)
         pos_n = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         last_idx    <= 2'd0;
         step_pulse  <= 1'b0;
         dir         <= 1'b1;
         pos         <= '0;
         err_illegal <= 1'b0;
         err_skip    <= 1'b0;
      end else begin
         state       <= state_n;
         last_idx    <= last_n;
         step_pulse  <= pulse_n;
         dir         <= dir_n;
         pos         <= pos_n;
         err_illegal <= ill_n;
         err_skip    <= skip_n;
      end
   end

endmodule

// File: tb/tb_stepmotor_phase_decoder.sv
// Self-checking bench for stepmotor_phase_decoder.
// Directed phase sequences checked against a sample-history model.
module tb_stepmotor_phase_decoder;

   localparam int S = 4;

   localparam logic [3:0] AC  = 4'b0101;
   localparam logic [3:0] DA  = 4'b1001;
   localparam logic [3:0] BD  = 4'b1010;
   localparam logic [3:0] CB  = 4'b0110;
   localparam logic [3:0] OFF = 4'b0000;
   localparam logic [3:0] BAD = 4'b1111;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  phase_in = 4'b0000;
   logic        clr_pos = 1'b0;
   logic        clr_err = 1'b0;

   logic        step_pulse, dir, valid, err_illegal, err_skip;
   logic [15:0] pos;
   logic        step_pulse4, dir4, valid4, err_illegal4, err_skip4;
   logic [3:0]  pos4;

   int checks = 0;
   int errors = 0;
   int npulse = 0;

   always #5 clk = ~clk;

   stepmotor_phase_decoder #(
      .CNT_WIDTH(16), .STABLE_CYCLES(S)
   ) dut (
      .clk(clk), .rst(rst), .phase_in(phase_in),
      .clr_pos(clr_pos), .clr_err(clr_err),
      .step_pulse(step_pulse), .dir(dir), .pos(pos),
      .valid(valid), .err_illegal(err_illegal),
      .err_skip(err_skip)
   );

   stepmotor_phase_decoder #(
      .CNT_WIDTH(4), .STABLE_CYCLES(S)
   ) dut4 (
      .clk(clk), .rst(rst), .phase_in(phase_in),
      .clr_pos(clr_pos), .clr_err(clr_err),
      .step_pulse(step_pulse4), .dir(dir4), .pos(pos4),
      .valid(valid4), .err_illegal(err_illegal4),
      .err_skip(err_skip4)
   );

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Accepted pattern = a code seen by the filter on S successive
   // samples; the filter sees phase_in two edges late.
   function automatic int idx_of(input logic [3:0] c);
      case (c)
         AC: return 0;
         DA: return 1;
         BD: return 2;
         CB: return 3;
         default: return -1;
      endcase
   endfunction

   logic [3:0] hist[$];
   int         mmode = 0;
   int         mlast = 0;
   int         mpos = 0;
   bit         mdir = 1'b1;
   bit         mpulse = 1'b0;
   bit         mill = 1'b0;
   bit         mskip = 1'b0;
   bit         mstb = 1'b0;
   logic [3:0] mcode = 4'b0;
   logic [3:0] macc = 4'b0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist = {};
         repeat (S + 2) hist.push_back(4'b0000);
         mmode = 0; mlast = 0; mpos = 0; mdir = 1'b1;
         mpulse = 1'b0; mill = 1'b0; mskip = 1'b0;
         mstb = 1'b0; mcode = 4'b0; macc = 4'b0;
      end else begin
         int m0, ix, d;
         bit same;
         m0 = mmode;
         mpulse = 1'b0;
         if (clr_err) begin
            mill = 1'b0; mskip = 1'b0;
            if (m0 == 2) mmode = 0;
         end
         if (mstb && m0 != 2) begin
            ix = idx_of(mcode);
            if (mcode == OFF) begin
               mmode = 0;
            end else if (ix < 0) begin
               mill = 1'b1; mmode = 2;
            end else if (m0 == 0) begin
               mlast = ix; mmode = 1;
            end else begin
               d = (ix - mlast + 4) % 4;
               mlast = ix;
               if (d == 1) begin
                  mpulse = 1'b1; mdir = 1'b1; mpos++;
               end else if (d == 3) begin
                  mpulse = 1'b1; mdir = 1'b0; mpos--;
               end else if (d == 2) begin
                  mskip = 1'b1; mmode = 2;
               end
            end
         end
         if (clr_pos) mpos = 0;
         hist.push_back(phase_in);
         void'(hist.pop_front());
         same = 1'b1;
         for (int i = 1; i < S; i++)
            if (hist[i] != hist[0]) same = 1'b0;
         mstb = same && (hist[0] != macc);
         if (mstb) begin
            mcode = hist[0];
            macc  = hist[0];
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      logic [31:0] ep;
      ep = 32'(mpos);
      chk("pulse", {31'b0, step_pulse}, {31'b0, mpulse});
      chk("dir",   {31'b0, dir},        {31'b0, mdir});
      chk("pos",   {16'b0, pos},        {16'b0, ep[15:0]});
      chk("pos4",  {28'b0, pos4},       {28'b0, ep[3:0]});
      chk("valid", {31'b0, valid},
          {31'b0, (mmode == 1)});
      chk("ill",   {31'b0, err_illegal}, {31'b0, mill});
      chk("skip",  {31'b0, err_skip},    {31'b0, mskip});
      if (step_pulse) npulse++;
   end

   // ---------------- directed stimulus ----------------
   task automatic drive(input logic [3:0] c, input int n);
      phase_in = c;
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic pulse_clr_err();
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
   endtask

   initial begin
      int base, k;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_pos",   {16'b0, pos}, 32'h0);
      chk("rst_dir",   {31'b0, dir}, 32'h1);
      chk("rst_valid", {31'b0, valid}, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      // T1: resync then four forward steps
      drive(AC, 20); drive(DA, 20); drive(BD, 20);
      drive(CB, 20); drive(AC, 20);
      chk("t1_steps", npulse, 4);
      chk("t1_pos",   {16'b0, pos}, 32'd4);
      chk("t1_dir",   {31'b0, dir}, 32'h1);
      chk("t1_valid", {31'b0, valid}, 32'h1);
      chk("t1_err",   {30'b0, err_illegal, err_skip}, 32'h0);

      // T2: reverse steps with latency check
      @(negedge clk);
      base = npulse;
      phase_in = CB;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!step_pulse && k < 20);
      chk("t2_latency", k, S + 3);
      drive(CB, 13);
      drive(BD, 20);
      chk("t2_steps", npulse - base, 2);
      chk("t2_pos",   {16'b0, pos}, 32'd2);
      chk("t2_dir",   {31'b0, dir}, 32'h0);

      // T3: glitch rejection then 4-cycle acceptance
      drive(CB, 20); drive(AC, 20);
      base = npulse;
      drive(DA, 3); drive(AC, 20);
      chk("t3_glitch", npulse - base, 0);
      chk("t3_pos",    {16'b0, pos}, 32'd4);
      drive(DA, 4); drive(BD, 20);
      chk("t3_accept", {16'b0, pos}, 32'd6);

      // T4: skip fault, ignore, clear, resync
      drive(CB, 20); drive(AC, 20);
      drive(BD, 20);
      chk("t4_skip",  {31'b0, err_skip}, 32'h1);
      chk("t4_valid", {31'b0, valid}, 32'h0);
      chk("t4_pos",   {16'b0, pos}, 32'd8);
      base = npulse;
      drive(CB, 20);
      chk("t4_ignored", npulse - base, 0);
      pulse_clr_err();
      #1;
      chk("t4_clr", {31'b0, err_skip}, 32'h0);
      drive(AC, 20);
      chk("t4_resync", {16'b0, pos}, 32'd8);
      drive(DA, 20);
      chk("t4_step", {16'b0, pos}, 32'd9);

      // T5: illegal code, then OFF in TRACK
      drive(BAD, 20);
      chk("t5_ill", {31'b0, err_illegal}, 32'h1);
      pulse_clr_err();
      drive(AC, 20); drive(DA, 20);
      drive(OFF, 20);
      chk("t5_off_valid", {31'b0, valid}, 32'h0);
      chk("t5_off_err", {30'b0, err_illegal, err_skip}, 32'h0);
      chk("t5_off_pos", {16'b0, pos}, 32'd10);
      drive(BD, 20);
      chk("t5_resync", {16'b0, pos}, 32'd10);

      // clr_err coincident with a fault strobe: fault wins
      phase_in = BAD;
      repeat (S + 2) @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      chk("clr_vs_fault", {31'b0, err_illegal}, 32'h1);
      drive(BAD, 10);
      pulse_clr_err();
      drive(BD, 20);

      // T6: clr_pos coincident with a step
      phase_in = CB;
      repeat (S + 2) @(negedge clk);
      clr_pos = 1'b1;
      @(negedge clk);
      clr_pos = 1'b0;
      chk("clrpos_pulse", {31'b0, step_pulse}, 32'h1);
      chk("clrpos_pos",   {16'b0, pos}, 32'h0);
      drive(CB, 20);
      drive(BD, 20);
      chk("wrap_neg16", {16'b0, pos}, 32'hFFFF);
      chk("wrap_neg4",  {28'b0, pos4}, 32'hF);
      drive(CB, 20); drive(AC, 20); drive(DA, 20); drive(BD, 20);
      drive(CB, 20); drive(AC, 20); drive(DA, 20); drive(BD, 20);
      chk("pos7_4", {28'b0, pos4}, 32'h7);
      drive(CB, 20);
      chk("wrap_pos4", {28'b0, pos4}, 32'h8);
      chk("pos8_16",   {16'b0, pos}, 32'h8);

      // Reset mid-step
      @(negedge clk);
      phase_in = AC;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_pos",   {16'b0, pos}, 32'h0);
      chk("mid_rst_valid", {31'b0, valid}, 32'h0);
      rst = 1'b1;
      base = npulse;
      drive(AC, 20);
      chk("post_rst_valid", {31'b0, valid}, 32'h1);
      chk("post_rst_steps", npulse - base, 0);
      chk("post_rst_pos",   {16'b0, pos}, 32'h0);
      drive(DA, 20);
      chk("post_rst_step",  {16'b0, pos}, 32'h1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
